// File: rtl/cal_cores_ram.sv
// cal_cores_ram: calibration store for the six cube reference colors.
// Averages N_AMOSTRAS RGB565 sensor samples per channel and writes the
// result into the selected table entry; combinational read port for the
// color classifier. Comes out of clear with the factory default palette.
module cal_cores_ram #(
   parameter int N_AMOSTRAS = 4,
   parameter int LOG2_N     = 2
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        iniciar,
   input  logic [2:0]  cor_idx,
   input  logic        cancelar,
   input  logic        amostra_valida,
   input  logic [15:0] amostra,
   input  logic [2:0]  addr,
   output logic [15:0] q,
   output logic        ocupado,
   output logic        pronto,
   output logic        erro
);

   localparam int N_CORES = 6;
   localparam int W_RB    = 5 + LOG2_N;
   localparam int W_G     = 6 + LOG2_N;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACUMULA = 2'd1,
      GRAVA   = 2'd2,
      FIM     = 2'd3
   } estado_t;

   estado_t r_estado;
   estado_t w_prox_estado;

   logic [2:0]        r_idx;
   logic [W_RB-1:0]   r_acc_r;
   logic [W_G-1:0]    r_acc_g;
   logic [W_RB-1:0]   r_acc_b;
   logic [LOG2_N-1:0] r_cnt;
   logic              r_erro;
   logic [15:0]       r_tab [N_CORES];

   logic w_inicio_ok;
   logic w_inicio_inv;
   logic w_aceita;
   logic w_ultima;
   logic [15:0] w_media;

   // Factory default palette, indexed by color number.
   function automatic logic [15:0] cor_padrao(input int i);
      case (i)
         0:       cor_padrao = 16'h5E0B;
         1:       cor_padrao = 16'h4801;
         2:       cor_padrao = 16'hC101;
         3:       cor_padrao = 16'h86C1;
         4:       cor_padrao = 16'h1E03;
         default: cor_padrao = 16'h12A9;
      endcase
   endfunction

   assign w_inicio_ok  = (r_estado == IDLE) && iniciar && (cor_idx <= 3'd5);
   assign w_inicio_inv = (r_estado == IDLE) && iniciar && (cor_idx >  3'd5);
   // cancelar wins over a sample arriving in the same cycle.
   assign w_aceita     = (r_estado == ACUMULA) && amostra_valida && !cancelar;
   assign w_ultima     = w_aceita && (r_cnt == LOG2_N'(N_AMOSTRAS - 1));
   // Truncating average: drop the LOG2_N low bits of each channel sum.
   assign w_media      = {r_acc_r[W_RB-1:LOG2_N], r_acc_g[W_G-1:LOG2_N],
                          r_acc_b[W_RB-1:LOG2_N]};

   // State register.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) r_estado <= IDLE;
      else       r_estado <= w_prox_estado;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns w_prox_estado; no latch.
      w_prox_estado = r_estado;
      case (r_estado)
         IDLE:    if (w_inicio_ok) w_prox_estado = ACUMULA;
         ACUMULA: begin
            if (cancelar)      w_prox_estado = IDLE;
            else if (w_ultima) w_prox_estado = GRAVA;
         end
         GRAVA:   w_prox_estado = FIM;
         FIM:     w_prox_estado = IDLE;
         default: w_prox_estado = IDLE;
      endcase
   end

   // Target latch, channel accumulators, sample counter and erro pulse.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_idx   <= '0;
         r_acc_r <= '0;
         r_acc_g <= '0;
         r_acc_b <= '0;
         r_cnt   <= '0;
         r_erro  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_erro <= w_inicio_inv;
         if (w_inicio_ok) begin
            r_idx   <= cor_idx;
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_cnt   <= '0;
         end else if (w_aceita) begin
            r_acc_r <= r_acc_r + W_RB'(amostra[15:11]);
            r_acc_g <= r_acc_g + W_G'(amostra[10:5]);
            r_acc_b <= r_acc_b + W_RB'(amostra[4:0]);
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   // Color table: six registers, written only in GRAVA.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         // NOTE: the table is flops, not RAM, so clear can restore the palette.
         for (int i = 0; i < N_CORES; i++) r_tab[i] <= cor_padrao(i);
      end else if (r_estado == GRAVA) begin
         for (int i = 0; i < N_CORES; i++)
            if (r_idx == 3'(i)) r_tab[i] <= w_media;
      end
   end

   // Combinational read port; out-of-range index reads zero.
   always_comb begin
      q = 16'h0000;
      for (int i = 0; i < N_CORES; i++)
         if (addr == 3'(i)) q = r_tab[i];
   end

   assign ocupado = (r_estado != IDLE);
   assign pronto  = (r_estado == FIM);
   assign erro    = r_erro;

endmodule
